fifo_sync_wconv: RTL and testbench

- Single-clock FIFO with asymmetric port widths. It generalises the team's fixed 8-in/16-out FIFO to any power-of-two width ratio, in either direction (upsize or downsize).
- Adds a synchronous flush, a registered-read valid strobe, and overflow/underflow pulses.
- Sits between pixel/byte streams and wide DDR/video datapaths wherever both sides share one clock domain.

---
 rtl/fifo_sync_wconv_if.sv | 39 +++
 rtl/fifo_sync_wconv.sv | 180 ++++++++++++++++++
 tb/tb_fifo_sync_wconv.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_sync_wconv_if.sv
// Bus bundle for fifo_sync_wconv: write side, read side and flush.
// The level width tracks the module's derived LVL_W, so both must share the same parameters.
interface fifo_sync_wconv_if #(
  parameter int WR_DATA_WIDTH = 8,
  parameter int RD_DATA_WIDTH = 16,
  parameter int DEPTH_WIDTH   = 10
);
  localparam int MAX_W = (WR_DATA_WIDTH > RD_DATA_WIDTH) ? WR_DATA_WIDTH : RD_DATA_WIDTH;
  localparam int MIN_W = (WR_DATA_WIDTH > RD_DATA_WIDTH) ? RD_DATA_WIDTH : WR_DATA_WIDTH;
  localparam int RATIO = MAX_W / MIN_W;
  localparam int LVL_W = DEPTH_WIDTH + $clog2(RATIO) + 1;

  logic                     flush;
  logic [WR_DATA_WIDTH-1:0] wr_data;
  logic                     wr_en;
  logic                     wr_full;
  logic                     almost_full;
  logic [LVL_W-1:0]         wr_water_level;
  logic                     overflow;
  logic [RD_DATA_WIDTH-1:0] rd_data;
  logic                     rd_en;
  logic                     rd_valid;
  logic                     rd_empty;
  logic                     almost_empty;
  logic [LVL_W-1:0]         rd_water_level;
  logic                     underflow;

  modport master (
    output flush, wr_data, wr_en, rd_en,
    input  wr_full, almost_full, wr_water_level, overflow,
    input  rd_data, rd_valid, rd_empty, almost_empty, rd_water_level, underflow
  );

  modport slave (
    input  flush, wr_data, wr_en, rd_en,
    output wr_full, almost_full, wr_water_level, overflow,
    output rd_data, rd_valid, rd_empty, almost_empty, rd_water_level, underflow
  );
endinterface

// File: rtl/fifo_sync_wconv.sv
// Single-clock FIFO with power-of-two width conversion (upsize, downsize or equal).
// Storage entries are max(WR,RD) wide; narrow sub-words are packed little-endian.
module fifo_sync_wconv #(
  parameter int WR_DATA_WIDTH    = 8,
  parameter int RD_DATA_WIDTH    = 16,
  parameter int DEPTH_WIDTH      = 10,
  parameter int ALMOST_FULL_NUM  = 2040,
  parameter int ALMOST_EMPTY_NUM = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  fifo_sync_wconv_if.slave  bus
);
  localparam int MAX_W      = (WR_DATA_WIDTH > RD_DATA_WIDTH) ? WR_DATA_WIDTH : RD_DATA_WIDTH;
  localparam int MIN_W      = (WR_DATA_WIDTH > RD_DATA_WIDTH) ? RD_DATA_WIDTH : WR_DATA_WIDTH;
  localparam int RATIO      = MAX_W / MIN_W;
  localparam int RATIO_LOG2 = $clog2(RATIO);
  localparam int IDX_W      = (RATIO_LOG2 > 0) ? RATIO_LOG2 : 1;
  localparam int LVL_W      = DEPTH_WIDTH + RATIO_LOG2 + 1;
  localparam int ENTRIES    = 1 << DEPTH_WIDTH;
  localparam bit UPSIZE     = RD_DATA_WIDTH > WR_DATA_WIDTH;
  localparam bit DOWNSIZE   = RD_DATA_WIDTH < WR_DATA_WIDTH;

  localparam int unsigned AF_NUM = ALMOST_FULL_NUM;
  localparam int unsigned AE_NUM = ALMOST_EMPTY_NUM;

  localparam logic [DEPTH_WIDTH:0]   CNT_FULL = (DEPTH_WIDTH+1)'(ENTRIES);
  localparam logic [DEPTH_WIDTH:0]   CNT_ONE  = (DEPTH_WIDTH+1)'(1);
  localparam logic [DEPTH_WIDTH-1:0] PTR_ONE  = DEPTH_WIDTH'(1);
  localparam logic [IDX_W-1:0]       IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0]       IDX_LAST = IDX_W'(RATIO - 1);

  logic [MAX_W-1:0]         mem [ENTRIES];
  logic [DEPTH_WIDTH-1:0]   wr_ptr_reg, wr_ptr_next;
  logic [DEPTH_WIDTH-1:0]   rd_ptr_reg, rd_ptr_next;
  logic [DEPTH_WIDTH:0]     mem_cnt_reg, mem_cnt_next;
  logic [RD_DATA_WIDTH-1:0] rd_data_reg;
  logic                     rd_valid_reg;
  logic                     overflow_reg;
  logic                     underflow_reg;

  logic                     wr_full;
  logic                     rd_empty;
  logic                     wr_acc;
  logic                     rd_acc;
  logic                     push;
  logic                     pop;
  logic [MAX_W-1:0]         push_word;
  logic [MAX_W-1:0]         head_word;
  logic [RD_DATA_WIDTH-1:0] rd_word;
  logic [LVL_W-1:0]         wr_lvl;
  logic [LVL_W-1:0]         rd_lvl;

  // The pack register adds no capacity: full and empty look only at committed entries.
  assign wr_full   = (mem_cnt_reg == CNT_FULL);
  assign rd_empty  = (mem_cnt_reg == '0);
  assign wr_acc    = bus.wr_en && !wr_full && !bus.flush;
  assign rd_acc    = bus.rd_en && !rd_empty && !bus.flush;
  assign head_word = mem[rd_ptr_reg];

  generate
    if (UPSIZE) begin : g_up
      logic [IDX_W-1:0]             pack_idx_reg;
      logic [(RATIO-1)*MIN_W-1:0]   pack_reg;

      // The last narrow word goes straight into the pushed entry, never into pack_reg.
      assign push      = wr_acc && (pack_idx_reg == IDX_LAST);
      assign pop       = rd_acc;
      assign push_word = {bus.wr_data, pack_reg};
      assign rd_word   = head_word;
      assign wr_lvl    = (LVL_W'(mem_cnt_reg) << RATIO_LOG2) + LVL_W'(pack_idx_reg);
      assign rd_lvl    = LVL_W'(mem_cnt_reg);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pack_idx_reg <= '0;
          pack_reg     <= '0;
        end else if (bus.flush) begin
          pack_idx_reg <= '0;
        end else if (wr_acc) begin
          pack_idx_reg <= pack_idx_reg + IDX_ONE;
          if (pack_idx_reg != IDX_LAST) begin
            pack_reg[pack_idx_reg*MIN_W +: MIN_W] <= bus.wr_data;
          end
        end
      end
    end else if (DOWNSIZE) begin : g_down
      logic [IDX_W-1:0] unpack_idx_reg;
      logic [MIN_W-1:0] head_slices [RATIO];

      for (genvar gi = 0; gi < RATIO; gi++) begin : g_slice
        assign head_slices[gi] = head_word[gi*MIN_W +: MIN_W];
      end

      assign push      = wr_acc;
      assign pop       = rd_acc && (unpack_idx_reg == IDX_LAST);
      assign push_word = bus.wr_data;
      assign rd_word   = head_slices[unpack_idx_reg];
      assign wr_lvl    = LVL_W'(mem_cnt_reg);
      assign rd_lvl    = (LVL_W'(mem_cnt_reg) << RATIO_LOG2) - LVL_W'(unpack_idx_reg);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          unpack_idx_reg <= '0;
        end else if (bus.flush) begin
          unpack_idx_reg <= '0;
        end else if (rd_acc) begin
          unpack_idx_reg <= unpack_idx_reg + IDX_ONE;
        end
      end
    end else begin : g_equal
      assign push      = wr_acc;
      assign pop       = rd_acc;
      assign push_word = bus.wr_data;
      assign rd_word   = head_word;
      assign wr_lvl    = LVL_W'(mem_cnt_reg);
      assign rd_lvl    = LVL_W'(mem_cnt_reg);
    end
  endgenerate

  always_comb begin
    wr_ptr_next  = wr_ptr_reg;
    rd_ptr_next  = rd_ptr_reg;
    mem_cnt_next = mem_cnt_reg;
    if (bus.flush) begin
      wr_ptr_next  = '0;
      rd_ptr_next  = '0;
      mem_cnt_next = '0;
    end else begin
      if (push) wr_ptr_next = wr_ptr_reg + PTR_ONE;
      if (pop)  rd_ptr_next = rd_ptr_reg + PTR_ONE;
      if (push && !pop) begin
        mem_cnt_next = mem_cnt_reg + CNT_ONE;
      end else if (pop && !push) begin
        mem_cnt_next = mem_cnt_reg - CNT_ONE;
      end
    end
  end

  // Storage array carries no reset so it maps onto RAM; reads only ever hit committed entries.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= push_word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      mem_cnt_reg   <= '0;
      rd_data_reg   <= '0;
      rd_valid_reg  <= 1'b0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      mem_cnt_reg   <= mem_cnt_next;
      rd_valid_reg  <= rd_acc;
      // Error pulses are registered alongside rd_valid; flush suppresses both.
      overflow_reg  <= bus.wr_en && wr_full && !bus.flush;
      underflow_reg <= bus.rd_en && rd_empty && !bus.flush;
      if (rd_acc) begin
        rd_data_reg <= rd_word;
      end
    end
  end

  assign bus.wr_full        = wr_full;
  assign bus.rd_empty       = rd_empty;
  assign bus.wr_water_level = wr_lvl;
  assign bus.rd_water_level = rd_lvl;
  assign bus.almost_full    = (32'(wr_lvl) >= AF_NUM);
  assign bus.almost_empty   = (32'(rd_lvl) <= AE_NUM);
  assign bus.rd_data        = rd_data_reg;
  assign bus.rd_valid       = rd_valid_reg;
  assign bus.overflow       = overflow_reg;
  assign bus.underflow      = underflow_reg;
endmodule

// File: tb/tb_fifo_sync_wconv.sv
// Bench for fifo_sync_wconv: an 8->16 and a 16->8 instance side by side, checked
// against byte-queue reference models, with directed scenarios followed by random traffic.
module tb_fifo_sync_wconv;
  localparam int DW  = 4;
  localparam int ENT = 1 << DW;
  localparam int AFN = 30;
  localparam int AEN = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fifo_sync_wconv_if #(.WR_DATA_WIDTH(8),  .RD_DATA_WIDTH(16), .DEPTH_WIDTH(DW)) up_if ();
  fifo_sync_wconv_if #(.WR_DATA_WIDTH(16), .RD_DATA_WIDTH(8),  .DEPTH_WIDTH(DW)) dn_if ();

  fifo_sync_wconv #(
    .WR_DATA_WIDTH(8), .RD_DATA_WIDTH(16), .DEPTH_WIDTH(DW),
    .ALMOST_FULL_NUM(AFN), .ALMOST_EMPTY_NUM(AEN)
  ) u_up (.clk(clk), .rst_n(rst_n), .bus(up_if));

  fifo_sync_wconv #(
    .WR_DATA_WIDTH(16), .RD_DATA_WIDTH(8), .DEPTH_WIDTH(DW),
    .ALMOST_FULL_NUM(AFN), .ALMOST_EMPTY_NUM(AEN)
  ) u_dn (.clk(clk), .rst_n(rst_n), .bus(dn_if));

  int total = 0;
  int bad = 0;

  // Reference: every FIFO is a queue of bytes in arrival order.
  logic [7:0]  q_up [$];
  logic [7:0]  q_dn [$];
  logic [15:0] exp_up_rd;
  logic [7:0]  exp_dn_rd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    up_if.wr_en = 1'b0; up_if.rd_en = 1'b0; up_if.flush = 1'b0;
    dn_if.wr_en = 1'b0; dn_if.rd_en = 1'b0; dn_if.flush = 1'b0;
  endtask

  // One clock: check flags against the model, clock the DUTs, update model, check read path.
  task automatic tick();
    int ue, de;
    bit u_wacc, u_racc, u_ovf, u_udf, u_fl;
    bit d_wacc, d_racc, d_ovf, d_udf, d_fl;
    logic [7:0]  u_wd;
    logic [15:0] d_wd;
    ue = q_up.size() / 2;
    de = (q_dn.size() + 1) / 2;
    check("up_empty", 32'(up_if.rd_empty),       32'(ue == 0));
    check("up_full",  32'(up_if.wr_full),        32'(ue == ENT));
    check("up_wlvl",  32'(up_if.wr_water_level), 32'(q_up.size()));
    check("up_rlvl",  32'(up_if.rd_water_level), 32'(ue));
    check("up_af",    32'(up_if.almost_full),    32'(q_up.size() >= AFN));
    check("up_ae",    32'(up_if.almost_empty),   32'(ue <= AEN));
    check("dn_empty", 32'(dn_if.rd_empty),       32'(q_dn.size() == 0));
    check("dn_full",  32'(dn_if.wr_full),        32'(de == ENT));
    check("dn_wlvl",  32'(dn_if.wr_water_level), 32'(de));
    check("dn_rlvl",  32'(dn_if.rd_water_level), 32'(q_dn.size()));
    check("dn_af",    32'(dn_if.almost_full),    32'(de >= AFN));
    check("dn_ae",    32'(dn_if.almost_empty),   32'(q_dn.size() <= AEN));
    u_fl = up_if.flush; u_wd = up_if.wr_data;
    d_fl = dn_if.flush; d_wd = dn_if.wr_data;
    u_wacc = up_if.wr_en && !u_fl && (ue < ENT);
    u_racc = up_if.rd_en && !u_fl && (ue > 0);
    u_ovf  = up_if.wr_en && !u_fl && (ue == ENT);
    u_udf  = up_if.rd_en && !u_fl && (ue == 0);
    d_wacc = dn_if.wr_en && !d_fl && (de < ENT);
    d_racc = dn_if.rd_en && !d_fl && (q_dn.size() > 0);
    d_ovf  = dn_if.wr_en && !d_fl && (de == ENT);
    d_udf  = dn_if.rd_en && !d_fl && (q_dn.size() == 0);
    @(posedge clk);
    #1;
    if (u_fl) begin
      q_up.delete();
    end else begin
      if (u_racc) begin
        exp_up_rd = {q_up[1], q_up[0]};
        void'(q_up.pop_front());
        void'(q_up.pop_front());
      end
      if (u_wacc) q_up.push_back(u_wd);
    end
    if (d_fl) begin
      q_dn.delete();
    end else begin
      if (d_racc) exp_dn_rd = q_dn.pop_front();
      if (d_wacc) begin
        q_dn.push_back(d_wd[7:0]);
        q_dn.push_back(d_wd[15:8]);
      end
    end
    check("up_valid", 32'(up_if.rd_valid),  32'(u_racc));
    check("up_rdata", 32'(up_if.rd_data),   32'(exp_up_rd));
    check("up_ovf",   32'(up_if.overflow),  32'(u_ovf));
    check("up_udf",   32'(up_if.underflow), 32'(u_udf));
    check("dn_valid", 32'(dn_if.rd_valid),  32'(d_racc));
    check("dn_rdata", 32'(dn_if.rd_data),   32'(exp_dn_rd));
    check("dn_ovf",   32'(dn_if.overflow),  32'(d_ovf));
    check("dn_udf",   32'(dn_if.underflow), 32'(d_udf));
  endtask

  // Four bytes into the upsizer and 0xBEEF into the downsizer, then two reads each.
  task automatic ordering(input string pfx);
    logic [7:0] bytes [4];
    bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      idle();
      up_if.wr_en = 1'b1; up_if.wr_data = bytes[i];
      if (i == 0) begin
        dn_if.wr_en = 1'b1; dn_if.wr_data = 16'hBEEF;
      end
      tick();
    end
    idle();
    check({pfx, "_dn_rlvl2"}, 32'(dn_if.rd_water_level), 32'd2);
    up_if.rd_en = 1'b1; dn_if.rd_en = 1'b1;
    tick();
    check({pfx, "_up_rd0"},   32'(up_if.rd_data),        32'h2211);
    check({pfx, "_up_v0"},    32'(up_if.rd_valid),       32'd1);
    check({pfx, "_dn_rd0"},   32'(dn_if.rd_data),        32'hEF);
    check({pfx, "_dn_rlvl1"}, 32'(dn_if.rd_water_level), 32'd1);
    tick();
    check({pfx, "_up_rd1"},   32'(up_if.rd_data),        32'h4433);
    check({pfx, "_up_v1"},    32'(up_if.rd_valid),       32'd1);
    check({pfx, "_up_empty"}, 32'(up_if.rd_empty),       32'd1);
    check({pfx, "_dn_rd1"},   32'(dn_if.rd_data),        32'hBE);
    check({pfx, "_dn_rlvl0"}, 32'(dn_if.rd_water_level), 32'd0);
    idle();
    tick();
    check({pfx, "_up_vidle"}, 32'(up_if.rd_valid), 32'd0);
    check({pfx, "_up_hold"},  32'(up_if.rd_data),  32'h4433);
  endtask

  initial begin
    idle();
    up_if.wr_data = '0;
    dn_if.wr_data = '0;
    exp_up_rd = '0;
    exp_dn_rd = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_up_empty", 32'(up_if.rd_empty),     32'd1);
    check("rst_up_ae",    32'(up_if.almost_empty), 32'd1);
    check("rst_up_full",  32'(up_if.wr_full),      32'd0);
    check("rst_up_af",    32'(up_if.almost_full),  32'd0);
    check("rst_dn_valid", 32'(dn_if.rd_valid),     32'd0);
    check("rst_dn_rdata", 32'(dn_if.rd_data),      32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    ordering("s1");

    // Partial pack word stays invisible to the read side.
    idle();
    up_if.wr_en = 1'b1; up_if.wr_data = 8'h5A;
    tick();
    idle();
    check("s2_empty", 32'(up_if.rd_empty),       32'd1);
    check("s2_wlvl",  32'(up_if.wr_water_level), 32'd1);
    check("s2_rlvl",  32'(up_if.rd_water_level), 32'd0);
    up_if.rd_en = 1'b1;
    tick();
    check("s2_udf", 32'(up_if.underflow), 32'd1);
    idle();
    up_if.flush = 1'b1;
    tick();
    idle();

    // Fill the upsizer to the brim.
    for (int i = 1; i <= 2 * ENT; i++) begin
      up_if.wr_en = 1'b1; up_if.wr_data = 8'($urandom);
      tick();
      if (i == AFN - 1 || i == AFN) check("s4_af", 32'(up_if.almost_full), 32'(i >= AFN));
    end
    check("s4_full", 32'(up_if.wr_full),        32'd1);
    check("s4_lvl",  32'(up_if.wr_water_level), 32'd32);
    tick();
    check("s4_ovf",     32'(up_if.overflow),       32'd1);
    check("s4_lvl_ovf", 32'(up_if.wr_water_level), 32'd32);
    up_if.rd_en = 1'b1;
    tick();
    check("s4_rw_ovf", 32'(up_if.overflow),       32'd1);
    check("s4_rw_lvl", 32'(up_if.wr_water_level), 32'd30);
    up_if.wr_en = 1'b0;
    for (int i = 0; i < ENT; i++) tick();
    idle();

    // Flush with both enables high on both instances.
    for (int i = 0; i < 20; i++) begin
      up_if.wr_en = 1'b1; up_if.wr_data = 8'($urandom);
      dn_if.wr_en = (i < 10); dn_if.wr_data = 16'($urandom);
      tick();
    end
    idle();
    check("s5_up_cnt", 32'(up_if.rd_water_level), 32'd10);
    check("s5_dn_cnt", 32'(dn_if.wr_water_level), 32'd10);
    up_if.flush = 1'b1; up_if.wr_en = 1'b1; up_if.rd_en = 1'b1;
    dn_if.flush = 1'b1; dn_if.wr_en = 1'b1; dn_if.rd_en = 1'b1;
    tick();
    idle();
    check("s5_up_empty", 32'(up_if.rd_empty),  32'd1);
    check("s5_up_valid", 32'(up_if.rd_valid),  32'd0);
    check("s5_up_ovf",   32'(up_if.overflow),  32'd0);
    check("s5_up_udf",   32'(up_if.underflow), 32'd0);
    check("s5_dn_empty", 32'(dn_if.rd_empty),  32'd1);
    check("s5_dn_valid", 32'(dn_if.rd_valid),  32'd0);

    // Asynchronous reset between edges with data and a partial pack word in flight.
    for (int i = 0; i < 3; i++) begin
      up_if.wr_en = 1'b1; up_if.wr_data = 8'($urandom);
      dn_if.wr_en = (i < 2); dn_if.wr_data = 16'($urandom);
      tick();
    end
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    check("s6_up_empty", 32'(up_if.rd_empty),       32'd1);
    check("s6_up_wlvl",  32'(up_if.wr_water_level), 32'd0);
    check("s6_up_ae",    32'(up_if.almost_empty),   32'd1);
    check("s6_up_rdata", 32'(up_if.rd_data),        32'd0);
    check("s6_dn_empty", 32'(dn_if.rd_empty),       32'd1);
    check("s6_dn_rlvl",  32'(dn_if.rd_water_level), 32'd0);
    q_up.delete();
    q_dn.delete();
    exp_up_rd = '0;
    exp_dn_rd = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    ordering("s6");

    // Random traffic: write-heavy half, then read-heavy half, rare flushes.
    for (int c = 0; c < 800; c++) begin
      int wp, rp;
      wp = (c < 400) ? 75 : 30;
      rp = (c < 400) ? 30 : 75;
      up_if.wr_en   = ($urandom_range(99) < wp);
      up_if.rd_en   = ($urandom_range(99) < rp);
      up_if.flush   = ($urandom_range(199) == 0);
      up_if.wr_data = 8'($urandom);
      dn_if.wr_en   = ($urandom_range(99) < wp);
      dn_if.rd_en   = ($urandom_range(99) < rp);
      dn_if.flush   = ($urandom_range(199) == 0);
      dn_if.wr_data = 16'($urandom);
      tick();
    end
    idle();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
